// File: rtl/avalon_sdram_arbiter.sv
// avalon_sdram_arbiter
// Shares one Avalon-MM SDRAM port between M0 (JTAG sample loader) and
// M1 (DRFM playback engine). Round-robin arbitration with a cap on the number
// of transfers per grant. Outstanding pipelined reads are tracked so that
// ReadDataValid always reaches the master that issued the read, and the bus
// is drained before it is handed to the other master.
//
// Optional build macro: AVALON_ARB_PRIO_EN
//   defined   -> M1 wins every idle tie and is never forced off the bus;
//                M0 is forced off at MAX_HOLD when M1 is waiting.
//   undefined -> plain round-robin, MAX_HOLD cap applies to both masters.
module avalon_sdram_arbiter #(
    parameter int ADDR_W   = 25,
    parameter int DATA_W   = 16,
    parameter int MAX_HOLD = 16,
    parameter int MAX_PEND = 8
) (
    input  logic                  i_Clk,
    input  logic                  i_nReset,
    // Master 0
    input  logic [ADDR_W-1:0]     i_M0_Address,
    input  logic [DATA_W/8-1:0]   i_M0_ByteEnable,
    input  logic                  i_M0_Write,
    input  logic                  i_M0_Read,
    input  logic [DATA_W-1:0]     i_M0_WriteData,
    output logic                  o_M0_WaitRequest,
    output logic [DATA_W-1:0]     o_M0_ReadData,
    output logic                  o_M0_ReadDataValid,
    // Master 1
    input  logic [ADDR_W-1:0]     i_M1_Address,
    input  logic [DATA_W/8-1:0]   i_M1_ByteEnable,
    input  logic                  i_M1_Write,
    input  logic                  i_M1_Read,
    input  logic [DATA_W-1:0]     i_M1_WriteData,
    output logic                  o_M1_WaitRequest,
    output logic [DATA_W-1:0]     o_M1_ReadData,
    output logic                  o_M1_ReadDataValid,
    // SDRAM controller side
    output logic [ADDR_W-1:0]     o_Avalon_Address,
    output logic [DATA_W/8-1:0]   o_Avalon_ByteEnable,
    output logic                  o_Avalon_Write,
    output logic                  o_Avalon_Read,
    output logic [DATA_W-1:0]     o_Avalon_WriteData,
    input  logic                  i_Avalon_WaitRequest,
    input  logic [DATA_W-1:0]     i_Avalon_ReadData,
    input  logic                  i_Avalon_ReadDataValid,
    // Status
    output logic                  o_Owner,
    output logic                  o_Busy
);

    localparam int PEND_W = $clog2(MAX_PEND + 1);
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GRANT = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]        r_state;
    logic              r_owner;
    logic [HOLD_W-1:0] r_hold;
    logic [PEND_W-1:0] r_pend;

    logic              w_req0;
    logic              w_req1;
    logic              w_ownReq;
    logic              w_otherReq;
    logic              w_selWrite;
    logic              w_selRead;
    logic              w_holdFull;
    logic              w_forceRel;
    logic              w_tieOwner;
    logic              w_inGrant;
    logic              w_active;
    logic              w_readStall;
    logic              w_ownerWait;
    logic              w_writeAcc;
    logic              w_readAcc;
    logic              w_release;
    logic              w_rdvValid;
    logic [PEND_W-1:0] w_pendNext;

    assign w_req0     = i_M0_Write | i_M0_Read;
    assign w_req1     = i_M1_Write | i_M1_Read;
    assign w_ownReq   = r_owner ? w_req1 : w_req0;
    assign w_otherReq = r_owner ? w_req0 : w_req1;

    // A master raising both strobes is treated as a write; the read is ignored.
    assign w_selWrite = r_owner ? i_M1_Write : i_M0_Write;
    assign w_selRead  = (r_owner ? i_M1_Read : i_M0_Read) & ~w_selWrite;

    assign w_holdFull  = (r_hold == HOLD_W'(MAX_HOLD));
    assign w_readStall = (r_pend == PEND_W'(MAX_PEND));
    assign w_inGrant   = (r_state == S_GRANT);

`ifdef AVALON_ARB_PRIO_EN
    assign w_forceRel = w_holdFull & w_otherReq & ~r_owner;
    assign w_tieOwner = 1'b1;
`else
    assign w_forceRel = w_holdFull & w_otherReq;
    assign w_tieOwner = ~r_owner;
`endif

    // On a forced release cycle the owner is stalled so the cap is exact.
    assign w_active = w_inGrant & ~w_forceRel;

    assign o_Avalon_Write      = w_active & w_selWrite;
    assign o_Avalon_Read       = w_active & w_selRead & ~w_readStall;
    assign o_Avalon_Address    = r_owner ? i_M1_Address    : i_M0_Address;
    assign o_Avalon_ByteEnable = r_owner ? i_M1_ByteEnable : i_M0_ByteEnable;
    assign o_Avalon_WriteData  = r_owner ? i_M1_WriteData  : i_M0_WriteData;

    assign w_ownerWait      = ~w_active | i_Avalon_WaitRequest | (w_selRead & w_readStall);
    assign o_M0_WaitRequest = r_owner ? 1'b1 : w_ownerWait;
    assign o_M1_WaitRequest = r_owner ? w_ownerWait : 1'b1;

    assign w_writeAcc = o_Avalon_Write & ~i_Avalon_WaitRequest;
    assign w_readAcc  = o_Avalon_Read  & ~i_Avalon_WaitRequest;
    assign w_release  = w_inGrant & (~w_ownReq | w_forceRel);

    // Returned data with nothing outstanding (e.g. after reset) is dropped.
    assign w_rdvValid         = i_Avalon_ReadDataValid & (r_pend != '0);
    assign o_M0_ReadDataValid = w_rdvValid & ~r_owner;
    assign o_M1_ReadDataValid = w_rdvValid & r_owner;
    assign o_M0_ReadData      = i_Avalon_ReadData;
    assign o_M1_ReadData      = i_Avalon_ReadData;

    assign o_Owner = r_owner;
    assign o_Busy  = (r_state != S_IDLE);

    // Outstanding-read count: up on accepted read, down on returned data.
    always_comb begin
        w_pendNext = r_pend;
        if (w_readAcc && !w_rdvValid) begin
            w_pendNext = r_pend + PEND_W'(1);
        end else if (!w_readAcc && w_rdvValid) begin
            w_pendNext = r_pend - PEND_W'(1);
        end
    end

    // Pending-read register.
    always_ff @(posedge i_Clk) begin
        if (!i_nReset) begin
            r_pend <= '0;
        end else begin
            r_pend <= w_pendNext;
        end
    end

    // Arbitration FSM: owner is only changed from IDLE, hold counts accepted transfers.
    always_ff @(posedge i_Clk) begin
        if (!i_nReset) begin
            r_state <= S_IDLE;
            r_owner <= 1'b1;
            r_hold  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req0 || w_req1) begin
                        r_state <= S_GRANT;
                        r_hold  <= '0;
                        r_owner <= (w_req0 && w_req1) ? w_tieOwner : w_req1;
                    end
                end
                S_GRANT: begin
                    if (w_release) begin
                        r_hold  <= '0;
                        r_state <= (r_pend != '0) ? S_DRAIN : S_IDLE;
                    end else if ((w_writeAcc || w_readAcc) && !w_holdFull) begin
                        r_hold <= r_hold + HOLD_W'(1);
                    end
                end
                S_DRAIN: begin
                    if (r_pend == '0) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
